// File: rtl/uncached_axi_bridge.sv
// SRAM-like uncached request port to single-beat AXI3 read/write master.
// One transaction in flight; request fields are latched on accept and drive the bus.
module uncached_axi_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_addr_ok,
   output logic        mem_data_ok,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AR   = 3'd1,
      R    = 3'd2,
      AWW  = 3'd3,
      B    = 3'd4
   } state_t;

   state_t      r_state;
   logic [28:0] r_addr;
   logic [1:0]  r_size;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic        r_data_ok;

   logic        w_accept;
   logic        w_aw_done;
   logic        w_w_done;
   logic [3:0]  w_strb;

   // The completion cycle blocks a new accept so data_ok and addr_ok never coincide.
   assign w_accept  = mem_req && (r_state == IDLE) && !r_data_ok;
   assign w_aw_done = !r_awvalid || awready;
   assign w_w_done  = !r_wvalid  || wready;

   always_comb begin
      w_strb = 4'b1111;
      case (r_size)
         2'd0:    w_strb = 4'b0001 << r_addr[1:0];
         2'd1:    w_strb = 4'b0011 << {r_addr[1], 1'b0};
         default: w_strb = 4'b1111;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_size    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_data_ok <= 1'b0;
      end else begin
         r_data_ok <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= mem_addr[28:0];
                  r_size  <= (mem_size == 2'd3) ? 2'd2 : mem_size;
                  r_wdata <= mem_wdata;
                  if (mem_wr) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= AWW;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= AR;
                  end
               end
            end
            AR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= R;
               end
            end
            R: begin
               if (rvalid) begin
                  r_rdata <= rdata;
                  if (rlast) begin
                     r_rready  <= 1'b0;
                     r_data_ok <= 1'b1;
                     r_state   <= IDLE;
                  end
               end
            end
            AWW: begin
               // AW and W complete independently, in either order or together.
               if (awready) r_awvalid <= 1'b0;
               if (wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= B;
               end
            end
            B: begin
               if (bvalid) begin
                  r_bready  <= 1'b0;
                  r_data_ok <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_addr_ok = w_accept;
   assign mem_data_ok = r_data_ok;
   assign mem_rdata   = r_rdata;

   assign araddr  = {3'b000, r_addr};
   assign arsize  = {1'b0, r_size};
   assign arvalid = r_arvalid;
   assign rready  = r_rready;

   assign awaddr  = {3'b000, r_addr};
   assign awsize  = {1'b0, r_size};
   assign awvalid = r_awvalid;
   assign wdata   = r_wdata;
   assign wstrb   = w_strb;
   assign wlast   = 1'b1;
   assign wvalid  = r_wvalid;
   assign bready  = r_bready;

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Bench for uncached_axi_bridge: AXI slave with programmable waits, transaction-level
// reference (address mask, strobe arithmetic, latency formula) and scenario tasks.
module tb_uncached_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   uncached_axi_bridge dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   typedef struct {
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          arw, rw, nb, aww, ww, bw;
   } txn_t;

   int n_checks = 0;
   int n_pass   = 0;

   // slave configuration and state
   int          ar_wait = 0, r_wait = 0, r_beats = 1, aw_wait = 0, w_wait = 0, b_wait = 0;
   int          ar_cnt = 0, r_cnt = 0, rbeat = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] rdq [2];
   bit          r_hs = 0;
   int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
   logic [3:0]  obs_strb;
   logic [2:0]  obs_awsize;

   always @(posedge clk) begin
      r_hs = rvalid && rready;
      if (arvalid && arready) n_ar++;
      if (awvalid && awready) n_aw++;
      if (wvalid && wready)   n_w++;
      if (bvalid && bready)   n_b++;
   end

   always @(negedge clk) begin
      if (rst) begin
         arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0; rdata = '0;
         ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; rbeat = 0; b_cnt = 0;
      end else begin
         if (arvalid) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
         else begin arready = 0; ar_cnt = 0; end
         if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
         else begin awready = 0; aw_cnt = 0; end
         if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
         else begin wready = 0; w_cnt = 0; end
         if (r_hs) begin rbeat++; r_cnt = 0; end
         if (rready && rbeat < r_beats) begin
            if (r_cnt >= r_wait) begin
               rvalid = 1; rdata = rdq[rbeat]; rlast = (rbeat == r_beats - 1);
            end else begin
               rvalid = 0; rlast = 0; r_cnt++;
            end
         end else begin
            rvalid = 0; rlast = 0;
            if (!rready) begin rbeat = 0; r_cnt = 0; end
         end
         if (bready) begin bvalid = (b_cnt >= b_wait); b_cnt++; end
         else begin bvalid = 0; b_cnt = 0; end
      end
   end

   function automatic txn_t mk(bit wr, logic [1:0] sz, logic [31:0] addr, logic [31:0] wd,
                               logic [31:0] rd, int arw, int rw, int nb, int aww, int ww, int bw);
      txn_t t;
      t.wr = wr; t.sz = sz; t.addr = addr; t.wd = wd; t.rd = rd;
      t.arw = arw; t.rw = rw; t.nb = nb; t.aww = aww; t.ww = ww; t.bw = bw;
      return t;
   endfunction

   task automatic drive(input txn_t t);
      mem_req = 1; mem_wr = t.wr; mem_size = t.sz; mem_addr = t.addr; mem_wdata = t.wd;
   endtask

   // One transaction from its accept cycle to the cycle after mem_data_ok.
   // presented: request already on the port. hold: keep mem_req high with n's fields.
   task automatic run_txn(input txn_t t, input bit presented, input bit hold, input txn_t n);
      int          cyc, lat_exp, a0, aw0, w0, b0, nbytes, off;
      logic [31:0] exp_addr;
      logic [2:0]  exp_size;
      logic [3:0]  exp_strb;
      ar_wait = t.arw; r_wait = t.rw; r_beats = t.nb; aw_wait = t.aww; w_wait = t.ww; b_wait = t.bw;
      rdq[0] = $urandom; rdq[1] = $urandom; rdq[t.nb-1] = t.rd;
      exp_addr = t.addr & 32'h1FFF_FFFF;
      exp_size = (t.sz == 2'd3) ? 3'd2 : {1'b0, t.sz};
      nbytes   = 1 << exp_size;
      off      = int'(t.addr[1:0]);
      off      = off - (off % nbytes);
      exp_strb = 4'(((1 << nbytes) - 1) << off);
      lat_exp  = t.wr ? 3 + ((t.aww > t.ww) ? t.aww : t.ww) + t.bw
                      : 2 + t.arw + t.nb * (t.rw + 1);
      if (!presented) begin @(negedge clk); drive(t); #1; end
      cyc = 0;
      while (mem_addr_ok !== 1'b1) begin
         if (cyc == 20) begin
            n_checks++; $display("FAIL accept_timeout addr=%h", t.addr);
            mem_req = 0; return;
         end
         @(negedge clk); #1; cyc++;
      end
      a0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
      for (cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (hold) drive(n);
         else begin
            mem_req = 0; mem_wr = 1'($urandom); mem_size = 2'($urandom);
            mem_addr = $urandom; mem_wdata = $urandom;
         end
         #1;
         if (hold) begin
            n_checks++;
            if (mem_addr_ok !== 1'b0) $display("FAIL busy_addr_ok cyc=%0d got=%b want=0", cyc, mem_addr_ok);
            else n_pass++;
         end
         if (!t.wr) begin
            n_checks++;
            if ({awvalid, wvalid, bready} !== 3'b000) $display("FAIL rd_write_ch got=%b want=000", {awvalid, wvalid, bready});
            else n_pass++;
            n_checks++;
            if (arvalid !== (n_ar == a0)) $display("FAIL arvalid cyc=%0d got=%b want=%b", cyc, arvalid, n_ar == a0);
            else n_pass++;
            if (arvalid) begin
               n_checks++;
               if ({araddr, arsize} !== {exp_addr, exp_size})
                  $display("FAIL ar_fields got=%h/%0d want=%h/%0d", araddr, arsize, exp_addr, exp_size);
               else n_pass++;
            end
            if (rready && n_ar == a0) begin
               n_checks++; $display("FAIL rready_early cyc=%0d", cyc);
            end
         end else begin
            n_checks++;
            if ({arvalid, rready} !== 2'b00) $display("FAIL wr_read_ch got=%b want=00", {arvalid, rready});
            else n_pass++;
            n_checks++;
            if ({awvalid, wvalid} !== {n_aw == aw0, n_w == w0})
               $display("FAIL aw_w_valid cyc=%0d got=%b%b want=%b%b", cyc, awvalid, wvalid, n_aw == aw0, n_w == w0);
            else n_pass++;
            if (awvalid) begin
               obs_awsize = awsize;
               n_checks++;
               if ({awaddr, awsize} !== {exp_addr, exp_size})
                  $display("FAIL aw_fields got=%h/%0d want=%h/%0d", awaddr, awsize, exp_addr, exp_size);
               else n_pass++;
            end
            if (wvalid) begin
               obs_strb = wstrb;
               n_checks++;
               if ({wdata, wstrb, wlast} !== {t.wd, exp_strb, 1'b1})
                  $display("FAIL w_fields got=%h/%b/%b want=%h/%b/1", wdata, wstrb, wlast, t.wd, exp_strb);
               else n_pass++;
            end
            if (bready && (n_aw == aw0 || n_w == w0)) begin
               n_checks++; $display("FAIL bready_early cyc=%0d", cyc);
            end
         end
         if (mem_data_ok) break;
      end
      n_checks++;
      if (cyc !== lat_exp) $display("FAIL latency addr=%h got=%0d want=%0d", t.addr, cyc, lat_exp);
      else n_pass++;
      if (!t.wr) begin
         n_checks++;
         if (mem_rdata !== t.rd) $display("FAIL rdata got=%h want=%h", mem_rdata, t.rd);
         else n_pass++;
      end
      n_checks++;
      if ({n_ar - a0, n_aw - aw0, n_w - w0, n_b - b0} !== (t.wr ? {32'd0, 32'd1, 32'd1, 32'd1} : {32'd1, 32'd0, 32'd0, 32'd0}))
         $display("FAIL hs_counts got=%0d/%0d/%0d/%0d", n_ar - a0, n_aw - aw0, n_w - w0, n_b - b0);
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if (mem_data_ok !== 1'b0) $display("FAIL data_ok_pulse got=%b want=0", mem_data_ok);
      else n_pass++;
      if (hold) begin
         n_checks++;
         if (mem_addr_ok !== 1'b1) $display("FAIL b2b_accept got=%b want=1", mem_addr_ok);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1; mem_req = 0; mem_wr = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, mem_data_ok, mem_addr_ok} !== 7'b0)
         $display("FAIL reset_ctrl got=%b want=0000000", {arvalid, awvalid, wvalid, rready, bready, mem_data_ok, mem_addr_ok});
      else n_pass++;
      n_checks++;
      if ({mem_rdata, awaddr, wdata} !== 96'b0) $display("FAIL reset_data got=%h/%h/%h want=0", mem_rdata, awaddr, wdata);
      else n_pass++;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_word_read();
      txn_t t;
      t = mk(0, 2'd2, 32'hBFAF_8000, 32'h0, 32'h1234_5678, 0, 0, 1, 0, 0, 0);
      run_txn(t, 0, 0, t);
      n_checks++;
      if (mem_rdata !== 32'h1234_5678) $display("FAIL word_read_hold got=%h want=12345678", mem_rdata);
      else n_pass++;
   endtask

   task automatic test_byte_write();
      txn_t t;
      t = mk(1, 2'd0, 32'hBFAF_F023, 32'hAB00_0000, 32'h0, 0, 0, 1, 0, 0, 1);
      run_txn(t, 0, 0, t);
      n_checks++;
      if ({obs_strb, obs_awsize} !== {4'b1000, 3'd0}) $display("FAIL byte_write got=%b/%0d want=1000/0", obs_strb, obs_awsize);
      else n_pass++;
   endtask

   task automatic test_w_delayed();
      txn_t t;
      t = mk(1, 2'd2, 32'hBFD0_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 0, 3, 0);
      run_txn(t, 0, 0, t);
   endtask

   task automatic test_ar_stall();
      txn_t t, n;
      t = mk(0, 2'd1, 32'hBFAF_0042, 32'h0, 32'h0BAD_BEEF, 5, 0, 1, 0, 0, 0);
      n = mk(1, 2'd1, 32'hBFAF_0046, 32'h5566_0000, 32'h0, 0, 0, 1, 1, 0, 0);
      run_txn(t, 0, 1, n);
      run_txn(n, 1, 0, n);
   endtask

   task automatic test_back_to_back();
      txn_t t, n;
      t = mk(0, 2'd3, 32'hBFC0_0100, 32'h0, 32'hA5A5_5A5A, 0, 0, 1, 0, 0, 0);
      n = mk(1, 2'd2, 32'hBFC0_0104, 32'h0102_0304, 32'h0, 0, 0, 1, 0, 0, 0);
      run_txn(t, 0, 1, n);
      run_txn(n, 1, 0, n);
   endtask

   task automatic test_async_reset();
      txn_t t;
      aw_wait = 30; w_wait = 30;
      @(negedge clk);
      drive(mk(1, 2'd2, 32'hBFAF_F000, 32'hFFFF_0000, 32'h0, 0, 0, 1, 30, 30, 0));
      @(negedge clk); mem_req = 0;
      @(negedge clk); #1;
      n_checks++;
      if ({awvalid, wvalid} !== 2'b11) $display("FAIL aww_entry got=%b%b want=11", awvalid, wvalid);
      else n_pass++;
      #1 rst = 1;
      #1;
      n_checks++;
      if ({awvalid, wvalid, bready} !== 3'b000) $display("FAIL async_rst got=%b want=000", {awvalid, wvalid, bready});
      else n_pass++;
      @(negedge clk); rst = 0;
      t = mk(0, 2'd0, 32'hBFAF_8003, 32'h0, 32'h0000_00C3, 0, 1, 2, 0, 0, 0);
      drive(t); #1;
      n_checks++;
      if (mem_addr_ok !== 1'b1) $display("FAIL post_rst_accept got=%b want=1", mem_addr_ok);
      else n_pass++;
      run_txn(t, 1, 0, t);
   endtask

   task automatic test_random();
      txn_t q[$];
      bit   holds[$];
      bit   pres, h;
      for (int i = 0; i < 24; i++) begin
         q.push_back(mk(1'($urandom), 2'($urandom), 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF),
                        $urandom, $urandom, $urandom_range(3), $urandom_range(2), $urandom_range(2, 1),
                        $urandom_range(3), $urandom_range(3), $urandom_range(2)));
         holds.push_back(1'($urandom));
      end
      pres = 0;
      for (int i = 0; i < 24; i++) begin
         h = (i < 23) ? holds[i] : 1'b0;
         run_txn(q[i], pres, h, (i < 23) ? q[i+1] : q[i]);
         pres = h;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word_read();
      test_byte_write();
      test_w_delayed();
      test_ar_stall();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uncached_axi_bridge.md
Name: uncached_axi_bridge

Overview:
- Downstream of the MEM stage's uncached path.
- Converts the SRAM-like request interface (mem_req/mem_wr/mem_size/mem_addr/mem_wdata → mem_rdata/mem_addr_ok/mem_data_ok) into single-beat AXI3 read/write transactions.
- One outstanding transaction at a time; serves the kseg1 uncached window (device registers, UART, LEDs).
- The integration top muxes it with the dcache AXI master onto the data port.

Parameters:
AXI_ID, 4'd1, value the integration top drives on arid/awid/wid (lock/cache/prot/len/burst tied constant there)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
mem_req  input  1  request valid
mem_wr  input  1  1 = write, 0 = read
mem_size  input  2  0 byte, 1 half, 2 word (3 treated as 2)
mem_addr  input  32  virtual address (kseg1)
mem_wdata  input  32  byte-lane-aligned write data
mem_rdata  output  32  read data, valid while mem_data_ok=1
mem_addr_ok  output  1  request accepted this cycle
mem_data_ok  output  1  transaction complete (one-cycle pulse)
araddr  output  32  read address
arsize  output  3  read size
arvalid  output  1  AR valid
arready  input  1  AR ready
rdata  input  32  read data
rlast  input  1  last beat
rvalid  input  1  R valid
rready  output  1  R ready
awaddr  output  32  write address
awsize  output  3  write size
awvalid  output  1  AW valid
awready  input  1  AW ready
wdata  output  32  write data
wstrb  output  4  byte strobes
wlast  output  1  always 1 (single beat)
wvalid  output  1  W valid
wready  input  1  W ready
bvalid  input  1  B valid
bready  output  1  B ready

Behaviour:
- FSM states: IDLE, AR, R, AWW, B.
- Reset (async, any state): state=IDLE; arvalid, awvalid, wvalid, rready, bready, mem_data_ok = 0; mem_rdata and latched request fields = 0. An in-flight AXI transaction is abandoned.
- mem_addr_ok = mem_req && state==IDLE && !mem_data_ok (combinational). On accept, latch addr, size, wr, wdata.
  - wr=0 → AR. wr=1 → AWW.
- Address: araddr = awaddr = {3'b000, latched_addr[28:0]}.
- Size: arsize = awsize = {1'b0, size'}, where size' = size with 3 mapped to 2.
- wstrb derivation:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1], 1'b0}
  - size 2/3: 4'b1111
- AR: arvalid=1 until arready sampled high → R.
- R: rready=1. On rvalid && rlast: capture rdata into mem_rdata, set mem_data_ok=1 for the next cycle, go to IDLE. rvalid without rlast: capture data, stay in R.
- AWW: awvalid and wvalid both asserted on entry. Each deasserts independently after its own handshake (either order, or same cycle). When both are done → B.
- B: bready=1. On bvalid: mem_data_ok=1 next cycle → IDLE.
- mem_data_ok is registered and lasts exactly one cycle. During that cycle the FSM is in IDLE but refuses a new request. Earliest back-to-back accept is the cycle after mem_data_ok.
- Minimum latency with a zero-wait slave, from the accept cycle T:
  - read: arvalid T+1, rvalid T+2, mem_data_ok T+3
  - write: aw/w T+1, bvalid T+2, mem_data_ok T+3
- Request inputs are ignored outside the accept cycle; latched values drive AXI, so mem_addr changes mid-transaction have no effect.
- Valid signals never drop before their handshake; address and data stay stable while valid=1.
- rresp/bresp are ignored; no bus-error exception.

Test Plan:
- Word read at 0xBFAF_8000: arready=1, rvalid+rlast next cycle with rdata=0x1234_5678. Expect araddr=0x1FAF_8000, arsize=2, mem_addr_ok at T, mem_data_ok only at T+3, mem_rdata=0x1234_5678.
- Byte write size=0 at 0xBFAF_F023, wdata=0xAB00_0000. Expect wstrb=4'b1000, awsize=0, wlast=1, mem_data_ok one cycle after bvalid.
- Write with awready at T+1 and wready delayed to T+4. Expect awvalid dropped after T+1, wvalid held through T+4, bready asserted only after both handshakes, single mem_data_ok.
- arready held 0 for 5 cycles with mem_req held high. Expect arvalid and araddr stable, mem_addr_ok=0 throughout, exactly one AR handshake.
- Back-to-back: mem_req held high, read then write. Expect the second mem_addr_ok in the cycle after the first mem_data_ok, never coincident with it.
- Async rst asserted mid-state AWW. Expect awvalid/wvalid=0 immediately (no clock edge); after release, state=IDLE and mem_addr_ok responds to mem_req.
